ita_oup_addr_gen: RTL and testbench
===================================

Name: ita_oup_addr_gen

Overview:
- Sits directly downstream of the ITA controller, in the output path.
- Records the tile coordinates of every output tile the controller launches.
- Pairs each requantized output beat leaving the engine with a write address.
- Issues per-tile and per-beat completion flags to the memory-side writer.
- Closes the loop between the controller's compute-side tile counters and the lagging output stream.

Parameters:
- M, 64, tile edge length (rows/cols per tile); power of two.
- N, 16, output elements per beat; power of two, N < M.
- Depth, 4, tag FIFO depth; equals the controller's output FIFO depth.
- CW, 8, tile counter width (tile_x/tile_y).
- AW, 32, element address width.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous, active-high reset
- clear_i  in  1  synchronous flush of FIFO, counters and error flag
- calc_en_i  in  1  controller compute-beat strobe
- last_inner_tile_i  in  1  current compute beat belongs to the last inner tile
- tile_x_i  in  CW  controller tile_x
- tile_y_i  in  CW  controller tile_y
- base_addr_i  in  AW  output matrix base element address
- row_stride_i  in  AW  output row stride, in elements
- oup_valid_i  in  1  engine output beat valid
- oup_ready_o  out  1  engine output beat accepted
- wr_valid_o  out  1  write request valid
- wr_ready_i  in  1  writer accepts request
- wr_addr_o  out  AW  element address of beat element 0
- wr_last_o  out  1  final beat of current tile
- tile_done_o  out  1  one-cycle pulse after a tile's final beat handshakes
- fifo_count_o  out  $clog2(Depth+1)  tags held
- overflow_o  out  1  sticky: push attempted while full

Behaviour:
- Reset (rst_i high, asynchronous):
  - FIFO empty; in_cnt, out_cnt = 0.
  - Outputs: oup_ready_o=0, wr_valid_o=0, wr_addr_o=0, wr_last_o=0, tile_done_o=0, fifo_count_o=0, overflow_o=0.
  - Reset mid-tile discards all tags with no residual state.
- clear_i: same effect as reset, synchronous; takes priority over push and pop in the same cycle.
- Input side:
  - in_cnt (log2(M*M/N) bits) increments on calc_en_i & last_inner_tile_i.
  - Wraps to 0 after M*M/N-1.
  - Push occurs when calc_en_i & last_inner_tile_i & in_cnt==0.
  - Pushed tag = {tile_x_i, tile_y_i, base_addr_i, row_stride_i}, sampled that cycle.
- Push while full and no pop in the same cycle:
  - Tag dropped; overflow_o set until reset/clear.
  - FIFO contents and count unchanged.
  - in_cnt still advances.
- Push while full with a pop in the same cycle: legal, no overflow, count unchanged.
- Output handshake (combinational, zero latency):
  - tag_valid = FIFO not empty.
  - wr_valid_o = oup_valid_i & tag_valid.
  - oup_ready_o = wr_ready_i & tag_valid.
  - A beat fires on oup_valid_i & wr_ready_i & tag_valid.
  - When empty, both are 0: the output stream stalls and no beat is lost.
  - oup_ready_o never depends on wr_valid_o.
- Address (head tag, out_cnt = beat index b in 0..M*M/N-1):
  - row = b & (M-1); colblk = b / M.
  - wr_addr_o = base + (tile_y*M + row)*row_stride + tile_x*M + colblk*N.
  - Arithmetic is modulo 2^AW. Products use full-width multiplies, truncated to AW.
- wr_last_o = tag_valid & (out_cnt == M*M/N-1).
- On each fire, out_cnt increments. On the last beat:
  - out_cnt wraps to 0 and the head tag pops.
  - tile_done_o pulses high in the following cycle.
- Simultaneous push into an empty FIFO and oup_valid_i in the same cycle:
  - The tag is not visible until the next cycle (registered FIFO).
  - oup_ready_o stays 0 that cycle.
- fifo_count_o is registered and reflects push/pop of the previous edge.

Test Plan:
- Single tile, base=0x1000, stride=64, tile (0,0), wr_ready_i=1:
  - beat0 addr 0x1000; beat1 0x1040; beat64 0x1010.
  - beat255 addr 0x1000+63*64+48=0x1FF0 with wr_last_o=1.
  - tile_done_o pulses in the next cycle.
- Tile (1,2), base=0, stride=128: beat0 addr 2*64*128+64=16448; beat255 addr (128+63)*128+64+48=24560.
- Backpressure:
  - Hold wr_ready_i=0 for 10 cycles mid-tile with oup_valid_i=1.
  - Required: oup_ready_o=0 throughout, wr_addr_o stable, out_cnt unchanged.
- Overflow:
  - Five tag pushes with no output beats.
  - Required: fifo_count_o=4 and overflow_o=1 after the 5th; first 4 tags drain in order.
- Full plus final pop: fifth push in the same cycle as beat 255 of the head tile. Required: overflow_o=0, fifo_count_o stays 4.
- Reset mid-tile:
  - Assert rst_i asynchronously at beat 100.
  - Required: outputs immediately 0.
  - After release, a new tile (3,0) starts at beat 0 with addr base+192.

Source files
------------

// File: rtl/ita_oup_addr_gen.sv
// ITA output address generator: tags launched output tiles and pairs
// each requantized output beat with its element write address.
module ita_oup_addr_gen #(
  parameter int unsigned M     = 64,
  parameter int unsigned N     = 16,
  parameter int unsigned Depth = 4,
  parameter int unsigned CW    = 8,
  parameter int unsigned AW    = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       clear_i,
  input  logic                       calc_en_i,
  input  logic                       last_inner_tile_i,
  input  logic [CW-1:0]              tile_x_i,
  input  logic [CW-1:0]              tile_y_i,
  input  logic [AW-1:0]              base_addr_i,
  input  logic [AW-1:0]              row_stride_i,
  input  logic                       oup_valid_i,
  output logic                       oup_ready_o,
  output logic                       wr_valid_o,
  input  logic                       wr_ready_i,
  output logic [AW-1:0]              wr_addr_o,
  output logic                       wr_last_o,
  output logic                       tile_done_o,
  output logic [$clog2(Depth+1)-1:0] fifo_count_o,
  output logic                       overflow_o
);

  localparam int unsigned BEATS = M * M / N;
  localparam int unsigned BW    = $clog2(BEATS);
  localparam int unsigned RW    = $clog2(M);
  localparam int unsigned PW    = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned KW    = $clog2(Depth + 1);

  typedef struct packed {
    logic [CW-1:0] tx;
    logic [CW-1:0] ty;
    logic [AW-1:0] base;
    logic [AW-1:0] stride;
  } tag_t;

  tag_t          mem [Depth];
  tag_t          head;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [KW-1:0] count;
  logic [BW-1:0] in_cnt;
  logic [BW-1:0] out_cnt;
  logic          done_q;
  logic          ovf_q;

  logic          tag_valid;
  logic          full;
  logic          push_req;
  logic          push;
  logic          fire;
  logic          last_beat;
  logic          pop;
  logic [AW-1:0] row;
  logic [AW-1:0] colblk;
  logic [AW-1:0] addr_raw;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  // Handshake, push/pop decisions and head-tag address arithmetic
  always_comb begin
    tag_valid = (count != '0);
    full      = (count == KW'(Depth));
    push_req  = calc_en_i & last_inner_tile_i & (in_cnt == '0);
    fire      = oup_valid_i & wr_ready_i & tag_valid;
    last_beat = (out_cnt == BW'(BEATS - 1));
    pop       = fire & last_beat;
    push      = push_req & (~full | pop);
    head      = mem[rd_ptr];
    row       = AW'(out_cnt[RW-1:0]);
    colblk    = AW'(out_cnt[BW-1:RW]);
    addr_raw  = head.base
              + (AW'(head.ty) * AW'(M) + row) * head.stride
              + AW'(head.tx) * AW'(M)
              + colblk * AW'(N);
  end

  // Output drive; address forced to 0 while no tag is held
  always_comb begin
    oup_ready_o  = wr_ready_i & tag_valid;
    wr_valid_o   = oup_valid_i & tag_valid;
    wr_addr_o    = tag_valid ? addr_raw : '0;
    wr_last_o    = tag_valid & last_beat;
    tile_done_o  = done_q;
    fifo_count_o = count;
    overflow_o   = ovf_q;
  end

  // Tag storage; contents are only visible through count, so no reset
  always_ff @(posedge clk_i) begin
    if (push && !clear_i) begin
      mem[wr_ptr] <= '{tx: tile_x_i, ty: tile_y_i,
                       base: base_addr_i, stride: row_stride_i};
    end
  end

  // FIFO pointers, beat counters, done pulse and sticky overflow
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      in_cnt  <= '0;
      out_cnt <= '0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (clear_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      in_cnt  <= '0;
      out_cnt <= '0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      if (calc_en_i && last_inner_tile_i) in_cnt <= in_cnt + 1'b1;
      if (fire) out_cnt <= out_cnt + 1'b1;
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      if (push && !pop) count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      if (push_req && full && !pop) ovf_q <= 1'b1;
      done_q <= pop;
    end
  end

endmodule

// File: tb/tb_ita_oup_addr_gen.sv
// Self-checking bench for ita_oup_addr_gen against a queue-based
// model of launched tiles and the beat address formula.
module tb_ita_oup_addr_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear;
  logic        calc_en;
  logic        last_inner;
  logic [7:0]  tile_x;
  logic [7:0]  tile_y;
  logic [31:0] base_addr;
  logic [31:0] row_stride;
  logic        oup_valid;
  logic        oup_ready;
  logic        wr_valid;
  logic        wr_ready;
  logic [31:0] wr_addr;
  logic        wr_last;
  logic        tile_done;
  logic [2:0]  fifo_count;
  logic        overflow;

  int vec = 0;
  int err = 0;

  typedef struct {
    logic [31:0] tx;
    logic [31:0] ty;
    logic [31:0] base;
    logic [31:0] stride;
  } mtag_t;

  mtag_t q[$];
  int    m_in;
  int    m_out;
  bit    m_ovf;
  bit    m_done;

  ita_oup_addr_gen dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .clear_i           (clear),
    .calc_en_i         (calc_en),
    .last_inner_tile_i (last_inner),
    .tile_x_i          (tile_x),
    .tile_y_i          (tile_y),
    .base_addr_i       (base_addr),
    .row_stride_i      (row_stride),
    .oup_valid_i       (oup_valid),
    .oup_ready_o       (oup_ready),
    .wr_valid_o        (wr_valid),
    .wr_ready_i        (wr_ready),
    .wr_addr_o         (wr_addr),
    .wr_last_o         (wr_last),
    .tile_done_o       (tile_done),
    .fifo_count_o      (fifo_count),
    .overflow_o        (overflow)
  );

  always #5 clk = ~clk;

  function automatic void m_reset();
    q.delete();
    m_in   = 0;
    m_out  = 0;
    m_ovf  = 1'b0;
    m_done = 1'b0;
  endfunction

  // Address of the current beat of the oldest outstanding tile.
  function automatic logic [31:0] m_addr();
    logic [31:0] row;
    logic [31:0] cb;
    if (q.size() == 0) return 32'd0;
    row = 32'(m_out % 64);
    cb  = 32'(m_out / 64);
    return q[0].base + (q[0].ty * 64 + row) * q[0].stride
         + q[0].tx * 64 + cb * 16;
  endfunction

  // Apply one clock edge to the model and the DUT with current inputs.
  task automatic adv();
    bit    tv;
    bit    fire;
    bit    pop;
    bit    pushr;
    mtag_t t;
    tv    = (q.size() > 0);
    fire  = oup_valid && wr_ready && tv;
    pop   = fire && (m_out == 255);
    pushr = calc_en && last_inner && (m_in == 0);
    if (clear) begin
      m_reset();
    end else begin
      m_done = pop;
      if (calc_en && last_inner) m_in = (m_in + 1) % 256;
      if (fire) m_out = (m_out + 1) % 256;
      if (pushr) begin
        if (q.size() < 4 || pop) begin
          t.tx = 32'(tile_x);
          t.ty = 32'(tile_y);
          t.base = base_addr;
          t.stride = row_stride;
          q.push_back(t);
        end else begin
          m_ovf = 1'b1;
        end
      end
      if (pop) void'(q.pop_front());
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    clear      = 1'b0;
    calc_en    = 1'b0;
    last_inner = 1'b0;
    oup_valid  = 1'b0;
    wr_ready   = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    adv();
    clear = 1'b0;
  endtask

  // Launch one tile: a counted push beat followed by 255 inner beats.
  task automatic push_tag(input logic [7:0] tx, input logic [7:0] ty,
                          input logic [31:0] b, input logic [31:0] s);
    calc_en    = 1'b1;
    last_inner = 1'b1;
    tile_x     = tx;
    tile_y     = ty;
    base_addr  = b;
    row_stride = s;
    adv();
    for (int i = 0; i < 255; i++) begin
      tile_x     = 8'($urandom);
      tile_y     = 8'($urandom);
      base_addr  = $urandom;
      row_stride = $urandom;
      adv();
    end
    calc_en    = 1'b0;
    last_inner = 1'b0;
  endtask

  // Drain n beats at full rate, checking each address against the model.
  task automatic drain(input int n, input string nm);
    oup_valid = 1'b1;
    wr_ready  = 1'b1;
    for (int i = 0; i < n; i++) begin
      #1;
      vec++;
      if (wr_addr !== m_addr()) begin
        err++;
        $display("FAIL %s addr beat %0d: got %h want %h",
                 nm, i, wr_addr, m_addr());
      end
      vec++;
      if (wr_last !== (m_out == 255)) begin
        err++;
        $display("FAIL %s last beat %0d: got %b want %b",
                 nm, i, wr_last, (m_out == 255));
      end
      adv();
    end
    oup_valid = 1'b0;
    wr_ready  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    tile_x = '0; tile_y = '0; base_addr = '0; row_stride = '0;
    @(negedge clk);
    oup_valid = 1'b1;
    wr_ready  = 1'b1;
    #1;
    vec++;
    if ({oup_ready, wr_valid, wr_last, tile_done, overflow} !== 5'b0) begin
      err++;
      $display("FAIL reset flags: got %b want 00000",
               {oup_ready, wr_valid, wr_last, tile_done, overflow});
    end
    vec++;
    if (wr_addr !== 32'd0) begin
      err++;
      $display("FAIL reset addr: got %h want 0", wr_addr);
    end
    vec++;
    if (fifo_count !== 3'd0) begin
      err++;
      $display("FAIL reset count: got %0d want 0", fifo_count);
    end
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();
    m_reset();
    @(negedge clk);
  endtask

  task automatic test_single_tile();
    push_tag(8'd0, 8'd0, 32'h1000, 32'd64);
    vec++;
    if (fifo_count !== 3'd1) begin
      err++;
      $display("FAIL single count: got %0d want 1", fifo_count);
    end
    oup_valid = 1'b1;
    wr_ready  = 1'b1;
    for (int b = 0; b < 256; b++) begin
      logic [31:0] want;
      #1;
      want = (b == 0) ? 32'h1000 : (b == 1) ? 32'h1040 :
             (b == 64) ? 32'h1010 : (b == 255) ? 32'h1FF0 : m_addr();
      vec++;
      if (wr_addr !== want) begin
        err++;
        $display("FAIL single addr beat %0d: got %h want %h",
                 b, wr_addr, want);
      end
      vec++;
      if ({wr_valid, oup_ready, wr_last} !== {2'b11, b == 255}) begin
        err++;
        $display("FAIL single hs beat %0d: got %b want %b",
                 b, {wr_valid, oup_ready, wr_last}, {2'b11, b == 255});
      end
      adv();
    end
    oup_valid = 1'b0;
    #1;
    vec++;
    if (tile_done !== 1'b1 || fifo_count !== 3'd0) begin
      err++;
      $display("FAIL single done: got %b/%0d want 1/0",
               tile_done, fifo_count);
    end
    adv();
    #1;
    vec++;
    if (tile_done !== 1'b0) begin
      err++;
      $display("FAIL single done pulse: got %b want 0", tile_done);
    end
    wr_ready = 1'b0;
  endtask

  task automatic test_tile_12();
    push_tag(8'd1, 8'd2, 32'd0, 32'd128);
    oup_valid = 1'b1;
    wr_ready  = 1'b1;
    #1;
    vec++;
    if (wr_addr !== 32'd16448) begin
      err++;
      $display("FAIL tile12 beat0: got %0d want 16448", wr_addr);
    end
    drain(255, "tile12");
    oup_valid = 1'b1;
    wr_ready  = 1'b1;
    #1;
    vec++;
    if (wr_addr !== 32'd24560 || wr_last !== 1'b1) begin
      err++;
      $display("FAIL tile12 beat255: got %0d/%b want 24560/1",
               wr_addr, wr_last);
    end
    adv();
    oup_valid = 1'b0;
    wr_ready  = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [31:0] held;
    push_tag(8'($urandom), 8'($urandom), $urandom, 32'($urandom_range(1, 4096)));
    drain(50, "bp_pre");
    oup_valid = 1'b1;
    wr_ready  = 1'b0;
    #1;
    held = m_addr();
    for (int i = 0; i < 10; i++) begin
      if (i != 0) #1;
      vec++;
      if (oup_ready !== 1'b0 || wr_valid !== 1'b1) begin
        err++;
        $display("FAIL bp hs cycle %0d: got %b%b want 01",
                 i, oup_ready, wr_valid);
      end
      vec++;
      if (wr_addr !== held) begin
        err++;
        $display("FAIL bp addr cycle %0d: got %h want %h", i, wr_addr, held);
      end
      adv();
    end
    wr_ready = 1'b1;
    #1;
    vec++;
    if (wr_addr !== held || oup_ready !== 1'b1) begin
      err++;
      $display("FAIL bp resume: got %h/%b want %h/1", wr_addr, oup_ready, held);
    end
    drain(206, "bp_post");
  endtask

  task automatic test_overflow();
    do_clear();
    for (int i = 0; i < 5; i++)
      push_tag(8'($urandom), 8'($urandom), $urandom, $urandom);
    #1;
    vec++;
    if (fifo_count !== 3'd4 || overflow !== 1'b1) begin
      err++;
      $display("FAIL ovf state: got %0d/%b want 4/1", fifo_count, overflow);
    end
    drain(4 * 256, "ovf_drain");
    #1;
    vec++;
    if (fifo_count !== 3'd0 || overflow !== 1'b1) begin
      err++;
      $display("FAIL ovf after drain: got %0d/%b want 0/1",
               fifo_count, overflow);
    end
  endtask

  task automatic test_full_pop();
    do_clear();
    for (int i = 0; i < 4; i++)
      push_tag(8'($urandom), 8'($urandom), $urandom, $urandom);
    drain(255, "fp_head");
    oup_valid  = 1'b1;
    wr_ready   = 1'b1;
    calc_en    = 1'b1;
    last_inner = 1'b1;
    tile_x     = 8'd7;
    tile_y     = 8'd9;
    base_addr  = 32'h0004_0000;
    row_stride = 32'd256;
    #1;
    vec++;
    if (wr_last !== 1'b1 || fifo_count !== 3'd4) begin
      err++;
      $display("FAIL fullpop pre: got %b/%0d want 1/4", wr_last, fifo_count);
    end
    adv();
    calc_en    = 1'b0;
    last_inner = 1'b0;
    oup_valid  = 1'b0;
    #1;
    vec++;
    if (overflow !== 1'b0 || fifo_count !== 3'd4 || tile_done !== 1'b1) begin
      err++;
      $display("FAIL fullpop post: got %b/%0d/%b want 0/4/1",
               overflow, fifo_count, tile_done);
    end
    drain(4 * 256, "fp_drain");
  endtask

  task automatic test_reset_mid_tile();
    logic [31:0] b;
    do_clear();
    push_tag(8'd5, 8'd1, 32'h2000, 32'd64);
    drain(100, "rmt_pre");
    oup_valid = 1'b1;
    wr_ready  = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    vec++;
    if ({oup_ready, wr_valid, wr_last, tile_done} !== 4'b0 ||
        wr_addr !== 32'd0 || fifo_count !== 3'd0) begin
      err++;
      $display("FAIL rmt async: got %b/%h/%0d want 0000/0/0",
               {oup_ready, wr_valid, wr_last, tile_done}, wr_addr, fifo_count);
    end
    m_reset();
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();
    b = 32'h0003_0000;
    push_tag(8'd3, 8'd0, b, 32'd100);
    oup_valid = 1'b1;
    wr_ready  = 1'b1;
    #1;
    vec++;
    if (wr_addr !== b + 32'd192 || wr_last !== 1'b0) begin
      err++;
      $display("FAIL rmt restart: got %h/%b want %h/0",
               wr_addr, wr_last, b + 32'd192);
    end
    drain(256, "rmt_tile");
  endtask

  task automatic test_random();
    do_clear();
    for (int c = 0; c < 4000; c++) begin
      clear      = ($urandom_range(0, 799) == 0);
      calc_en    = ($urandom_range(0, 9) < 8);
      last_inner = ($urandom_range(0, 9) < 8);
      tile_x     = 8'($urandom);
      tile_y     = 8'($urandom);
      base_addr  = $urandom;
      row_stride = $urandom;
      oup_valid  = ($urandom_range(0, 9) < 7);
      wr_ready   = ($urandom_range(0, 9) < 7);
      #1;
      vec++;
      if (oup_ready !== (wr_ready && q.size() > 0) ||
          wr_valid !== (oup_valid && q.size() > 0)) begin
        err++;
        $display("FAIL rand hs cycle %0d: got %b%b", c, oup_ready, wr_valid);
      end
      vec++;
      if (wr_addr !== m_addr()) begin
        err++;
        $display("FAIL rand addr cycle %0d: got %h want %h",
                 c, wr_addr, m_addr());
      end
      vec++;
      if (wr_last !== (q.size() > 0 && m_out == 255) ||
          tile_done !== m_done) begin
        err++;
        $display("FAIL rand last/done cycle %0d: got %b%b want %b%b",
                 c, wr_last, tile_done, (q.size() > 0 && m_out == 255), m_done);
      end
      vec++;
      if (fifo_count !== 3'(q.size()) || overflow !== m_ovf) begin
        err++;
        $display("FAIL rand count/ovf cycle %0d: got %0d/%b want %0d/%b",
                 c, fifo_count, overflow, q.size(), m_ovf);
      end
      adv();
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_single_tile();
    test_tile_12();
    test_backpressure();
    test_overflow();
    test_full_pop();
    test_reset_mid_tile();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
